approx_mult_ctrl: RTL and testbench
===================================

Name: approx_mult_ctrl

Overview:
- Control FSM that sequences the approximate-multiplier datapath. It sits directly upstream of the datapath and drives every load, shift, clear, enable and write strobe.
- It walks the 16-entry input RAM as 8 operand pairs. For each operand it shifts left until the leading one reaches bit 15, or until the shift cap is hit.
- It captures the top 8 bits of each operand into reg2/reg3 and writes {total shift count, product} to the output RAM.
- It reports completion to the system.

Parameters:
- MAX_SHIFT, 15, per-operand shift cap. SHIFT exits when num3 equals this value; it bounds the all-zero operand.
- LAST_ADDR, 15, index of the last input RAM entry (num1 width 4).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a full 8-pair run; sampled only in IDLE
- x15  in  1  bit 15 of the datapath shift register (combinational)
- num1C  in  4  input RAM address counter value
- num3  in  4  per-operand shift counter value
- num2C  in  5  accumulated shift count for the pair (status only; unused by next-state logic)
- clr1  out  1  synchronous clear of the address counter
- en1  out  1  increment of the address counter
- ld1  out  1  load the shift register from input RAM[num1]
- shL1  out  1  shift the shift register left by 1
- ld2  out  1  capture shLout[15:8] into reg2 (operand A)
- ld3  out  1  capture shLout[15:8] into reg3 (operand B)
- clr2, en2  out  1  clear / increment the pair shift counter num2
- clr3, en3  out  1  clear / increment the per-operand shift counter num3
- wen  out  1  output RAM write strobe; address = num1[3:1], data = {num2, product}
- busy  out  1  high in every state except IDLE
- done  out  1  registered one-cycle pulse at run end

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; done=0. All decoded strobes are 0, including busy. Reset mid-run aborts immediately; no further wen.
- Strobes are decoded combinationally from state and status (Mealy). Only the state register and done are flops.
- IDLE: start=1 -> INIT. Otherwise stay. start while busy is ignored.
- INIT: assert clr1, clr2, clr3 -> LOAD_A.
- LOAD_A: assert ld1 -> SHIFT_A.
- SHIFT_A:
  - If x15=1 or num3==MAX_SHIFT -> CAP_A, with no strobes.
  - Else assert shL1, en2, en3 and stay.
  - If x15=1 and num3==MAX_SHIFT are both true in the same cycle, no shift occurs.
- CAP_A: assert ld2, en1, clr3 -> LOAD_B.
- LOAD_B: assert ld1 -> SHIFT_B.
- SHIFT_B: same rule as SHIFT_A -> CAP_B.
- CAP_B: assert ld3 -> WRITE. num1 is not incremented, so num1 stays on the odd entry.
- WRITE: assert wen for exactly one cycle -> NEXT. The product is combinational from reg2/reg3, which are valid this cycle.
- NEXT:
  - If num1C==LAST_ADDR -> DONE.
  - Else assert en1, clr2, clr3 -> LOAD_A.
- DONE: done register set for one cycle -> IDLE. A new start is accepted from IDLE on the following cycle.
- Shift counts:
  - An operand with leading one at bit k takes 15-k shifts; SHIFT dwell is 16-k cycles.
  - An all-zero operand takes MAX_SHIFT shifts, then exits with reg = 0.
  - num2 never exceeds 2*MAX_SHIFT = 30, so it fits in 5 bits.
- Latency:
  - A pair with both leading ones at bit 15 takes 8 cycles from LOAD_A to the NEXT exit.
  - A full run is 1 (INIT) + sum over pairs of (8 + shiftsA + shiftsB) + 1 (DONE) cycles.
- Exactly 8 wen pulses per run, at addresses 0..7 in order.

Decomposition:
- Package approx_mult_pkg holds:
  - the state encoding localparams: IDLE, INIT, LOAD_A, SHIFT_A, CAP_A, LOAD_B, SHIFT_B, CAP_B, WRITE, NEXT, DONE (4-bit);
  - MAX_SHIFT;
  - LAST_ADDR.
- No sub-module: single FSM with a state register, next-state block and output decode. Counters and storage stay in the datapath.
- The bench binds this block to the existing datapath plus a behavioural input-RAM preload.

Test Plan:
- Reset mid-SHIFT_A (rst low 1 cycle): state IDLE, all strobes 0, busy=0, no wen until the next start.
- All 16 entries 0x8000, start pulse:
  - 8 wen pulses at addresses 0..7, each with num2=0;
  - run length 1+8*8+1 = 66 cycles from start to done;
  - done high for exactly 1 cycle.
- Pair (0x0001, 0x00F0) at entries 0/1:
  - SHIFT_A runs 15 shL1 cycles, SHIFT_B runs 8;
  - reg2=0x80, reg3=0xF0;
  - write to address 0 with num2=23.
- Pair (0x0000, 0xFFFF): operand A stops at num3=15 with reg2=0x00; B takes 0 shifts; write num2=15, product 0.
- start held high through the whole run: exactly one run; a second run begins only after the IDLE cycle that follows done.
- Check num1 sequencing: at each wen, num1[0]=1 and num1[3:1] equals the pair index; after the final NEXT, num1C=15.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared encodings and limits for the approximate-multiplier control path.
// The state values are fixed so they stay stable in waveforms and datapath debug.
package approx_mult_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        INIT    = 4'd1,
        LOAD_A  = 4'd2,
        SHIFT_A = 4'd3,
        CAP_A   = 4'd4,
        LOAD_B  = 4'd5,
        SHIFT_B = 4'd6,
        CAP_B   = 4'd7,
        WRITE   = 4'd8,
        NEXT    = 4'd9,
        DONE    = 4'd10
    } state_t;

    localparam logic [3:0] MAX_SHIFT = 4'd15;
    localparam logic [3:0] LAST_ADDR = 4'd15;

endpackage

// File: rtl/approx_mult_ctrl.sv
// Control FSM for the approximate-multiplier datapath: normalises each operand pair,
// captures the top bytes and writes {shift count, product} to the output RAM.
module approx_mult_ctrl
    import approx_mult_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       x15,
    input  logic [3:0] num1C,
    input  logic [3:0] num3,
    input  logic [4:0] num2C,
    output logic       clr1,
    output logic       en1,
    output logic       ld1,
    output logic       shL1,
    output logic       ld2,
    output logic       ld3,
    output logic       clr2,
    output logic       en2,
    output logic       clr3,
    output logic       en3,
    output logic       wen,
    output logic       busy,
    output logic       done
);

    state_t state_q, state_d;
    logic   done_q;
    logic   shift_exit;

    // num2C is status only and deliberately does not steer the FSM.
    logic unused_num2c;
    assign unused_num2c = ^num2C;

    // Leading one normalised, or the cap reached (covers the all-zero operand).
    assign shift_exit = x15 || (num3 == MAX_SHIFT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == DONE);
        end
    end

    assign done = done_q;
    assign busy = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        clr1    = 1'b0;
        en1     = 1'b0;
        ld1     = 1'b0;
        shL1    = 1'b0;
        ld2     = 1'b0;
        ld3     = 1'b0;
        clr2    = 1'b0;
        en2     = 1'b0;
        clr3    = 1'b0;
        en3     = 1'b0;
        wen     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = INIT;
            end
            INIT: begin
                clr1    = 1'b1;
                clr2    = 1'b1;
                clr3    = 1'b1;
                state_d = LOAD_A;
            end
            LOAD_A: begin
                ld1     = 1'b1;
                state_d = SHIFT_A;
            end
            SHIFT_A: begin
                if (shift_exit) begin
                    state_d = CAP_A;
                end else begin
                    shL1 = 1'b1;
                    en2  = 1'b1;
                    en3  = 1'b1;
                end
            end
            CAP_A: begin
                ld2     = 1'b1;
                en1     = 1'b1;
                clr3    = 1'b1;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                ld1     = 1'b1;
                state_d = SHIFT_B;
            end
            SHIFT_B: begin
                if (shift_exit) begin
                    state_d = CAP_B;
                end else begin
                    shL1 = 1'b1;
                    en2  = 1'b1;
                    en3  = 1'b1;
                end
            end
            CAP_B: begin
                // num1 stays on the odd entry so WRITE addresses with num1[3:1].
                ld3     = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                wen     = 1'b1;
                state_d = NEXT;
            end
            NEXT: begin
                if (num1C == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    en1     = 1'b1;
                    clr2    = 1'b1;
                    clr3    = 1'b1;
                    state_d = LOAD_A;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_approx_mult_ctrl.sv
// Self-checking bench: behavioural datapath around the controller, with expected
// results computed from operand arithmetic rather than from the FSM's states.
module tb_approx_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        x15;
    logic [3:0]  num1;
    logic [3:0]  num3;
    logic [4:0]  num2;
    logic        clr1, en1, ld1, shL1, ld2, ld3, clr2, en2, clr3, en3, wen, busy, done;

    logic [15:0] mem [16];
    logic [15:0] shreg;
    logic [7:0]  reg2, reg3;
    logic [15:0] product;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [2:0]  addr;
        logic        lsb;
        logic [4:0]  n2;
        logic [15:0] prod;
        logic [7:0]  r2;
        logic [7:0]  r3;
    } wrec_t;

    wrec_t wq[$];
    int    busy_cycles;
    int    done_cycles;

    int exp_n2 [8];
    int exp_pr [8];
    int exp_r2 [8];
    int exp_r3 [8];
    int exp_cycles;

    always #5 clk = ~clk;

    approx_mult_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x15   (x15),
        .num1C (num1),
        .num3  (num3),
        .num2C (num2),
        .clr1  (clr1),
        .en1   (en1),
        .ld1   (ld1),
        .shL1  (shL1),
        .ld2   (ld2),
        .ld3   (ld3),
        .clr2  (clr2),
        .en2   (en2),
        .clr3  (clr3),
        .en3   (en3),
        .wen   (wen),
        .busy  (busy),
        .done  (done)
    );

    // Behavioural datapath: counters, shift register and operand registers.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            num1  <= '0;
            num2  <= '0;
            num3  <= '0;
            shreg <= '0;
            reg2  <= '0;
            reg3  <= '0;
        end else begin
            if (clr1) num1 <= '0;
            else if (en1) num1 <= num1 + 4'd1;
            if (clr2) num2 <= '0;
            else if (en2) num2 <= num2 + 5'd1;
            if (clr3) num3 <= '0;
            else if (en3) num3 <= num3 + 4'd1;
            if (ld1) shreg <= mem[num1];
            else if (shL1) shreg <= {shreg[14:0], 1'b0};
            if (ld2) reg2 <= shreg[15:8];
            if (ld3) reg3 <= shreg[15:8];
        end
    end

    assign x15     = shreg[15];
    assign product = 16'(reg2 * reg3);

    always @(negedge clk) begin
        if (wen) wq.push_back('{num1[3:1], num1[0], num2, product, reg2, reg3});
        if (busy) busy_cycles++;
        if (done) done_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int shifts_of(input logic [15:0] x);
        if (x == 16'd0) return 15;
        return 15 - ($clog2(int'(x) + 1) - 1);
    endfunction

    function automatic int top_byte(input logic [15:0] x);
        int v;
        v = (int'(x) << shifts_of(x)) & 32'hFFFF;
        return v >> 8;
    endfunction

    function automatic logic [15:0] rand_op();
        int k;
        k = $urandom_range(0, 16);
        if (k == 16) return 16'd0;
        return 16'((32'd1 << k) | ($urandom & ((32'd1 << k) - 1)));
    endfunction

    task automatic build_model();
        exp_cycles = 2;
        for (int p = 0; p < 8; p++) begin
            int sa, sb;
            sa = shifts_of(mem[2*p]);
            sb = shifts_of(mem[2*p+1]);
            exp_n2[p] = sa + sb;
            exp_r2[p] = top_byte(mem[2*p]);
            exp_r3[p] = top_byte(mem[2*p+1]);
            exp_pr[p] = exp_r2[p] * exp_r3[p];
            exp_cycles += 8 + sa + sb;
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " timeout"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic do_run(input string tag, input bit hold);
        int m;
        build_model();
        wq.delete();
        busy_cycles = 0;
        done_cycles = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        wait_done(tag);
        check({tag, " num1 end"}, 32'(num1), 32'd15);
        @(negedge clk);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " cycles"}, 32'(busy_cycles), 32'(exp_cycles));
        check({tag, " done width"}, 32'(done_cycles), 32'd1);
        check({tag, " wen count"}, 32'(wq.size()), 32'd8);
        m = (wq.size() < 8) ? wq.size() : 8;
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s addr%0d", tag, i), 32'(wq[i].addr), 32'(i));
            check($sformatf("%s lsb%0d", tag, i), 32'(wq[i].lsb), 32'd1);
            check($sformatf("%s num2_%0d", tag, i), 32'(wq[i].n2), 32'(exp_n2[i]));
            check($sformatf("%s prod%0d", tag, i), 32'(wq[i].prod), 32'(exp_pr[i]));
            check($sformatf("%s reg2_%0d", tag, i), 32'(wq[i].r2), 32'(exp_r2[i]));
            check($sformatf("%s reg3_%0d", tag, i), 32'(wq[i].r3), 32'(exp_r3[i]));
        end
        if (hold) begin
            // Start still high: the IDLE cycle above is followed by a fresh run.
            @(negedge clk);
            check({tag, " restart"}, 32'(busy), 32'd1);
            start = 1'b0;
            wait_done({tag, " second"});
            @(negedge clk);
            check({tag, " second wen count"}, 32'(wq.size()), 32'd16);
        end
    endtask

    initial begin
        logic [12:0] strobes;

        for (int i = 0; i < 16; i++) mem[i] = 16'h8000;
        repeat (2) @(negedge clk);
        strobes = {clr1, en1, ld1, shL1, ld2, ld3, clr2, en2, clr3, en3, wen, busy, done};
        check("reset strobes", 32'(strobes), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);

        do_run("norm", 1'b0);
        check("norm 66", 32'(busy_cycles), 32'd66);

        for (int i = 0; i < 16; i++) mem[i] = rand_op();
        mem[0] = 16'h0001;
        mem[1] = 16'h00F0;
        do_run("pairA", 1'b0);
        if (wq.size() > 0) begin
            check("pairA num2", 32'(wq[0].n2), 32'd23);
            check("pairA reg2", 32'(wq[0].r2), 32'h80);
            check("pairA reg3", 32'(wq[0].r3), 32'hF0);
        end

        for (int i = 0; i < 16; i++) mem[i] = rand_op();
        mem[0] = 16'h0000;
        mem[1] = 16'hFFFF;
        do_run("pairZ", 1'b0);
        if (wq.size() > 0) begin
            check("pairZ num2", 32'(wq[0].n2), 32'd15);
            check("pairZ prod", 32'(wq[0].prod), 32'd0);
            check("pairZ reg2", 32'(wq[0].r2), 32'd0);
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = rand_op();
            do_run($sformatf("rand%0d", r), 1'b0);
        end

        for (int i = 0; i < 16; i++) mem[i] = rand_op();
        do_run("hold", 1'b1);

        // Abort a run mid-SHIFT_A with an asynchronous reset.
        for (int i = 0; i < 16; i++) mem[i] = 16'h0001;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-abort shifting", 32'(shL1), 32'd1);
        rst = 1'b0;
        #1;
        strobes = {clr1, en1, ld1, shL1, ld2, ld3, clr2, en2, clr3, en3, wen, busy, done};
        check("abort strobes", 32'(strobes), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wq.delete();
        repeat (30) @(negedge clk);
        check("abort no wen", 32'(wq.size()), 32'd0);
        check("abort busy", 32'(busy), 32'd0);

        for (int i = 0; i < 16; i++) mem[i] = rand_op();
        do_run("recover", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
